breath_led_multi: RTL

BREATH_LED_MULTI -- requirements
Module: breath_led_multi

---
 rtl/breath_pkg.sv | 19 +
 rtl/pwm_channel.sv | 55 +++++
 rtl/breath_led_multi.sv | 118 +++++++++++
 3 files changed

// File: rtl/breath_pkg.sv
// Shared encodings for the multi-channel breathing LED driver.
// Mode values match the 2-bit per-channel mode field.
package breath_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ON     = 2'b01,
    MODE_BREATH = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    UP      = 2'b00,
    HOLD_HI = 2'b01,
    DOWN    = 2'b10,
    HOLD_LO = 2'b11
  } ramp_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: picks its duty from the shared ramp, latches it at period
// start and drives a registered PWM output.
module pwm_channel
  import breath_pkg::*;
#(
  parameter int PWM_MAX    = 3464,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int LW         = $clog2(PWM_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          phase_inv,
  input  logic [LW-1:0] level,
  input  ramp_state_e   state,
  input  logic [LW-1:0] pwm_cnt,
  output logic          led
);

  localparam logic [LW-1:0] FULL = LW'(PWM_MAX);

  logic [LW-1:0] duty_sel;
  logic [LW-1:0] duty_q;
  logic [LW-1:0] duty_eff;
  logic          blink_on;

  always_comb begin
    blink_on = ((state == UP) || (state == HOLD_HI)) ^ phase_inv;
    duty_sel = '0;
    case (mode_e'(mode))
      MODE_OFF:    duty_sel = '0;
      MODE_ON:     duty_sel = FULL;
      MODE_BREATH: duty_sel = phase_inv ? (FULL - level) : level;
      MODE_BLINK:  duty_sel = blink_on ? FULL : '0;
      default:     duty_sel = '0;
    endcase
  end

  // The first count of a period already compares against the freshly chosen duty.
  assign duty_eff = (pwm_cnt == '0) ? duty_sel : duty_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= '0;
      led    <= ACTIVE_LOW;
    end else if (en) begin
      if (pwm_cnt == '0) duty_q <= duty_sel;
      led <= (pwm_cnt < duty_eff) ^ ACTIVE_LOW;
    end else begin
      led <= ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/breath_led_multi.sv
// Multi-channel breathing LED driver: a shared triangle ramp engine plus CH
// independent PWM channels.
module breath_led_multi
  import breath_pkg::*;
#(
  parameter int CH         = 4,
  parameter int PWM_MAX    = 3464,
  parameter int RAMP_STEP  = 1,
  parameter int HOLD       = 0,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [2*CH-1:0]                  mode,
  input  logic [CH-1:0]                    phase_inv,
  output logic [CH-1:0]                    led,
  output logic [$clog2(PWM_MAX+1)-1:0]     level,
  output logic                             peak_pulse,
  output logic                             trough_pulse
);

  localparam int LW  = $clog2(PWM_MAX + 1);
  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [LW:0]    STEP_W    = (LW+1)'(RAMP_STEP);
  localparam logic [LW:0]    FULL_W    = (LW+1)'(PWM_MAX);
  localparam logic [LW-1:0]  FULL      = LW'(PWM_MAX);
  localparam logic [LW-1:0]  CNT_LAST  = LW'(PWM_MAX - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD > 0) ? HOLD - 1 : 0);

  logic [LW-1:0]  pwm_cnt;
  logic [HCW-1:0] hold_cnt;
  ramp_state_e    state;
  logic [LW:0]    up_sum;
  logic [LW-1:0]  up_next;
  logic [LW-1:0]  down_next;
  logic           tick;

  // Saturating ramp arithmetic, computed one bit wider so the sum cannot wrap.
  always_comb begin
    up_sum    = {1'b0, level} + STEP_W;
    up_next   = (up_sum >= FULL_W) ? FULL : up_sum[LW-1:0];
    down_next = ({1'b0, level} > STEP_W) ? (level - STEP_W[LW-1:0]) : '0;
    tick      = en && (pwm_cnt == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt      <= '0;
      level        <= '0;
      state        <= UP;
      hold_cnt     <= '0;
      peak_pulse   <= 1'b0;
      trough_pulse <= 1'b0;
    end else begin
      peak_pulse   <= 1'b0;
      trough_pulse <= 1'b0;
      if (en) pwm_cnt <= tick ? '0 : pwm_cnt + 1'b1;
      if (tick) begin
        case (state)
          UP: begin
            level <= up_next;
            if (up_next == FULL) begin
              peak_pulse <= 1'b1;
              hold_cnt   <= '0;
              state      <= (HOLD == 0) ? DOWN : HOLD_HI;
            end
          end
          HOLD_HI: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= DOWN;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          DOWN: begin
            level <= down_next;
            if (down_next == '0) begin
              trough_pulse <= 1'b1;
              hold_cnt     <= '0;
              state        <= (HOLD == 0) ? UP : HOLD_LO;
            end
          end
          HOLD_LO: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= UP;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: state <= UP;
        endcase
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_channel #(
      .PWM_MAX    (PWM_MAX),
      .ACTIVE_LOW (ACTIVE_LOW),
      .LW         (LW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode[2*i +: 2]),
      .phase_inv (phase_inv[i]),
      .level     (level),
      .state     (state),
      .pwm_cnt   (pwm_cnt),
      .led       (led[i])
    );
  end

endmodule
